// File: rtl/cpu_run_ctrl_if.sv
// Run-control bus: operator switches and CPU halt in,
// CPU clock-enable/reset and status out.
interface cpu_run_ctrl_if;
    logic        sw_go;
    logic        sw_rst;
    logic        sw_speed;
    logic        btn_step;
    logic        halt_req;
    logic        cpu_ce;
    logic        cpu_rst;
    logic [1:0]  speed_sel;
    logic [2:0]  state;
    logic [31:0] cycle_cnt;

    modport master (
        output sw_go, sw_rst, sw_speed, btn_step, halt_req,
        input  cpu_ce, cpu_rst, speed_sel, state, cycle_cnt
    );

    modport slave (
        input  sw_go, sw_rst, sw_speed, btn_step, halt_req,
        output cpu_ce, cpu_rst, speed_sel, state, cycle_cnt
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: debounced operator switches drive a
// run/pause/step/halt FSM that gates the CPU clock enable.
module cpu_run_ctrl #(
    parameter int unsigned DIV_BASE   = 10_000_000,
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    cpu_run_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        RSTH  = 3'd0,
        PAUSE = 3'd1,
        RUN   = 3'd2,
        STEP  = 3'd3,
        HALT  = 3'd4
    } state_e;

    // Channel order in the vectors: go, rst, speed, step.
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    localparam int unsigned P0 = (DIV_BASE      > 0) ? DIV_BASE      : 1;
    localparam int unsigned P1 = (DIV_BASE / 2  > 0) ? DIV_BASE / 2  : 1;
    localparam int unsigned P2 = (DIV_BASE / 4  > 0) ? DIV_BASE / 4  : 1;
    localparam int unsigned P3 = (DIV_BASE / 16 > 0) ? DIV_BASE / 16 : 1;

    logic [3:0]          raw;
    logic [3:0]          s1_q, s2_q;
    logic [3:0]          deb_q, deb_d;
    logic [3:0][CW-1:0]  deb_cnt_q, deb_cnt_d;
    logic [1:0]          edge_q;
    logic                speed_rise, step_rise;
    logic [1:0]          speed_q, speed_d;
    logic [31:0]         period;
    logic [31:0]         tick_cnt_q, tick_cnt_d;
    logic                tick;
    state_e              state_q, state_d;
    logic                cpu_ce_q, cpu_ce_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic [31:0]         cycle_cnt_q, cycle_cnt_d;

    assign raw = {bus.btn_step, bus.sw_speed, bus.sw_rst, bus.sw_go};

    // Debounce: adopt the synchronized level once it has held
    // a different value for DEB_CYCLES consecutive cycles.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            deb_d[i]     = deb_q[i];
            deb_cnt_d[i] = '0;
            if (s2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = s2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign speed_rise = deb_q[2] & ~edge_q[0];
    assign step_rise  = deb_q[3] & ~edge_q[1];

    // Tick period for the current speed and the tick strobe.
    always_comb begin
        period = P0;
        unique case (speed_q)
            2'd0: period = P0;
            2'd1: period = P1;
            2'd2: period = P2;
            2'd3: period = P3;
            default: period = P0;
        endcase
        tick = (tick_cnt_q == period - 32'd1);
    end

    // Next-state decode; soft reset beats everything else.
    always_comb begin
        state_d = state_q;
        if (deb_q[1]) begin
            state_d = RSTH;
        end else begin
            unique case (state_q)
                RSTH:  state_d = PAUSE;
                PAUSE: begin
                    if (deb_q[0])      state_d = RUN;
                    else if (step_rise) state_d = STEP;
                end
                RUN: begin
                    if (bus.halt_req)  state_d = HALT;
                    else if (!deb_q[0]) state_d = PAUSE;
                end
                STEP:  state_d = bus.halt_req ? HALT : PAUSE;
                HALT:  state_d = HALT;
                default: state_d = RSTH;
            endcase
        end
    end

    // Outputs are computed from the next state so the registered
    // ce/rst line up with the state they belong to.
    always_comb begin
        speed_d    = speed_rise ? speed_q + 2'd1 : speed_q;
        tick_cnt_d = tick_cnt_q + 32'd1;
        if (state_q != RUN || speed_rise || tick) begin
            tick_cnt_d = '0;
        end
        cpu_rst_d = (state_d == RSTH);
        cpu_ce_d  = 1'b0;
        if (state_d == STEP) begin
            cpu_ce_d = 1'b1;
        end else if (state_q == RUN && state_d == RUN) begin
            cpu_ce_d = tick;
        end
        cycle_cnt_d = cycle_cnt_q;
        if (state_d == RSTH) begin
            cycle_cnt_d = '0;
        end else if (cpu_ce_q && cycle_cnt_q != 32'hFFFF_FFFF) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
    end

    // All state, including the FSM, in one register block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= '0;
            s2_q        <= '0;
            deb_q       <= '0;
            deb_cnt_q   <= '0;
            edge_q      <= '0;
            speed_q     <= '0;
            tick_cnt_q  <= '0;
            state_q     <= RSTH;
            cpu_ce_q    <= 1'b0;
            cpu_rst_q   <= 1'b1;
            cycle_cnt_q <= '0;
        end else begin
            s1_q        <= raw;
            s2_q        <= s1_q;
            deb_q       <= deb_d;
            deb_cnt_q   <= deb_cnt_d;
            edge_q      <= deb_q[3:2];
            speed_q     <= speed_d;
            tick_cnt_q  <= tick_cnt_d;
            state_q     <= state_d;
            cpu_ce_q    <= cpu_ce_d;
            cpu_rst_q   <= cpu_rst_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign bus.cpu_ce    = cpu_ce_q;
    assign bus.cpu_rst   = cpu_rst_q;
    assign bus.speed_sel = speed_q;
    assign bus.state     = state_q;
    assign bus.cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl with DIV_BASE=16, DEB_CYCLES=4:
// hand sequences for run/speed/async reset, table for the FSM walk.
module tb_cpu_run_ctrl;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    cpu_run_ctrl_if bus ();

    cpu_run_ctrl #(
        .DIV_BASE   (16),
        .DEB_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic go;
        logic rst;
        logic spd;
        logic stp;
        logic hlt;
        int   hold;
        int   st;
        int   ce;
        int   steps;
        int   cyc;
    } vec_t;

    vec_t tbl [18];
    vec_t sb [$];

    task automatic chk(input string name, input longint act,
                       input longint exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ce(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.cpu_ce !== 1'b1 && n < 100);
    endtask

    function automatic vec_t mk(input logic go, input logic rst,
                                input logic spd, input logic stp,
                                input logic hlt, input int hold,
                                input int st, input int ce,
                                input int steps, input int cyc);
        vec_t v;
        v.go = go; v.rst = rst; v.spd = spd; v.stp = stp;
        v.hlt = hlt; v.hold = hold; v.st = st; v.ce = ce;
        v.steps = steps; v.cyc = cyc;
        return v;
    endfunction

    initial begin
        int   n;
        int   ce_n;
        int   st_n;
        int   ovl;
        vec_t e;
        int   per_exp [4];

        n_chk  = 0;
        n_pass = 0;

        //           go rst spd stp hlt hold st  ce stp cyc
        tbl[0]  = mk(0, 1, 0, 0, 0, 12, 0, -1, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 10, 1,  0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 1, 0, 10, 1,  1, 1, 1);
        tbl[3]  = mk(0, 0, 0, 0, 0, 10, 1,  0, 0, 1);
        tbl[4]  = mk(0, 0, 0, 1, 0,  2, 1,  0, 0, 1);
        tbl[5]  = mk(0, 0, 0, 0, 0, 10, 1,  0, 0, 1);
        tbl[6]  = mk(1, 0, 0, 0, 0,  9, 2,  0, 0, 1);
        tbl[7]  = mk(1, 0, 0, 0, 1,  1, 4,  0, 0, 1);
        tbl[8]  = mk(0, 0, 0, 0, 1, 10, 4,  0, 0, 1);
        tbl[9]  = mk(1, 0, 0, 1, 0, 10, 4,  0, 0, 1);
        tbl[10] = mk(0, 0, 0, 0, 0, 10, 4,  0, 0, 1);
        tbl[11] = mk(0, 1, 0, 0, 0, 10, 0,  0, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 10, 1,  0, 0, 0);
        tbl[13] = mk(1, 0, 0, 0, 0, 30, 2,  1, 0, 1);
        tbl[14] = mk(0, 0, 0, 0, 0,  8, 1,  0, 0, 1);
        tbl[15] = mk(0, 0, 0, 1, 1, 10, 4,  1, 1, 2);
        tbl[16] = mk(0, 1, 0, 0, 0, 10, 0,  0, 0, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 10, 1,  0, 0, 0);

        per_exp[0] = 8;
        per_exp[1] = 4;
        per_exp[2] = 1;
        per_exp[3] = 16;

        rst_n        = 1'b0;
        bus.sw_go    = 1'b0;
        bus.sw_rst   = 1'b0;
        bus.sw_speed = 1'b0;
        bus.btn_step = 1'b0;
        bus.halt_req = 1'b0;
        repeat (3) tick();
        chk("rst_state", bus.state, 0);
        chk("rst_cpu_rst", bus.cpu_rst, 1);
        chk("rst_cpu_ce", bus.cpu_ce, 0);
        chk("rst_speed", bus.speed_sel, 0);
        chk("rst_cycle_cnt", bus.cycle_cnt, 0);

        rst_n = 1'b1;
        tick();
        chk("first_edge_pause", bus.state, 1);

        bus.sw_go = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.state !== 3'd2 && n < 30);
        chk("run_latency", n, 7);
        for (int k = 0; k < 3; k++) begin
            wait_ce(n);
            chk("run_period16", n, 16);
        end
        tick();
        chk("run_cycle_cnt3", bus.cycle_cnt, 3);

        for (int k = 0; k < 4; k++) begin
            bus.sw_speed = 1'b1;
            repeat (10) tick();
            chk("speed_sel", bus.speed_sel, (k + 1) % 4);
            bus.sw_speed = 1'b0;
            repeat (10) tick();
            wait_ce(n);
            wait_ce(n);
            chk("speed_period", n, per_exp[k]);
        end

        foreach (tbl[i]) begin
            bus.sw_go    = tbl[i].go;
            bus.sw_rst   = tbl[i].rst;
            bus.sw_speed = tbl[i].spd;
            bus.btn_step = tbl[i].stp;
            bus.halt_req = tbl[i].hlt;
            sb.push_back(tbl[i]);
            ce_n = 0;
            st_n = 0;
            ovl  = 0;
            for (int c = 0; c < tbl[i].hold; c++) begin
                tick();
                if (bus.cpu_ce === 1'b1) ce_n++;
                if (bus.state === 3'd3) st_n++;
                if (bus.cpu_ce === 1'b1 && bus.cpu_rst === 1'b1) ovl++;
            end
            e = sb.pop_front();
            chk($sformatf("v%0d_state", i), bus.state, e.st);
            chk($sformatf("v%0d_cpu_rst", i), bus.cpu_rst,
                (e.st == 0) ? 1 : 0);
            if (e.ce >= 0) chk($sformatf("v%0d_ce_count", i), ce_n, e.ce);
            chk($sformatf("v%0d_step_cycles", i), st_n, e.steps);
            chk($sformatf("v%0d_cycle_cnt", i), bus.cycle_cnt, e.cyc);
            chk($sformatf("v%0d_ce_rst_overlap", i), ovl, 0);
            chk($sformatf("v%0d_speed", i), bus.speed_sel, 0);
        end

        bus.sw_speed = 1'b1;
        repeat (10) tick();
        bus.sw_speed = 1'b0;
        bus.sw_go    = 1'b1;
        repeat (10) tick();
        chk("pre_async_state", bus.state, 2);
        wait_ce(n);
        chk("pre_async_period", n < 100 ? 1 : 0, 1);
        tick();
        chk("pre_async_speed", bus.speed_sel, 1);
        chk("pre_async_cycle_cnt", bus.cycle_cnt, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_state", bus.state, 0);
        chk("async_cpu_rst", bus.cpu_rst, 1);
        chk("async_cpu_ce", bus.cpu_ce, 0);
        chk("async_speed", bus.speed_sel, 0);
        chk("async_cycle_cnt", bus.cycle_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
